wb_cfg_slave: RTL and testbench

- Synthesizable Wishbone classic slave: the responder counterpart to the simulation Wishbone master in the queueing system bench.
- Holds the queueing core's writable configuration registers and exposes read-only status words.
- Sits between the Wishbone bus (wb_cyc/stb/we/addr/data/ack) and the queue manager/scheduler.
- Single clock; synchronous reset.

---
 rtl/wb_cfg_pkg.sv | 27 ++
 rtl/wb_cfg_decode.sv | 45 ++++
 rtl/wb_cfg_slave.sv | 166 ++++++++++++++++
 tb/tb_wb_cfg_slave.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_cfg_pkg.sv
// Shared constants and types for the Wishbone configuration slave.
// Build option: WB_CFG_PIPE_EN adds a registered address-decode stage.
package wb_cfg_pkg;

   localparam logic [8:0] CFG_OFFS   = 9'h000;
   localparam logic [8:0] STAT_OFFS  = 9'h100;
   localparam logic [8:0] WRCNT_OFFS = 9'h1F8;
   localparam logic [8:0] ID_OFFS    = 9'h1FC;

   localparam logic [31:0] ID_VALUE       = 32'h5146_0100;
   localparam logic [31:0] UNMAPPED_VALUE = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      ACK    = 2'd2
   } state_e;

   typedef struct packed {
      logic       hit_cfg;
      logic       hit_stat;
      logic       hit_wrcnt;
      logic       hit_id;
      logic [5:0] idx;
   } dec_t;

endpackage

// File: rtl/wb_cfg_decode.sv
// Combinational address decoder for the configuration slave window.
// Build option: WB_CFG_PIPE_EN (decoder is shared by both builds).
module wb_cfg_decode
   import wb_cfg_pkg::*;
#(
   parameter int                    ADDR_WIDTH    = 32,
   parameter int                    NUM_CFG_REGS  = 8,
   parameter int                    NUM_STAT_REGS = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0
) (
   input  logic [ADDR_WIDTH-1:0] addr_i,
   output logic                  hit_cfg_o,
   output logic                  hit_stat_o,
   output logic                  hit_wrcnt_o,
   output logic                  hit_id_o,
   output logic [5:0]            idx_o
);

   localparam logic [6:0] NCFG  = 7'(NUM_CFG_REGS);
   localparam logic [6:0] NSTAT = 7'(NUM_STAT_REGS);

   logic [ADDR_WIDTH-1:0] offs;
   logic                  in_range;
   logic [8:0]            loffs;
   logic                  unused_byte_lane;

   // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
   assign offs     = addr_i - BASE_ADDR;
   assign in_range = offs < ADDR_WIDTH'(512);
   assign loffs    = offs[8:0];
   assign idx_o    = loffs[7:2];

   assign unused_byte_lane = ^loffs[1:0];

   always_comb begin
      hit_wrcnt_o = in_range && (loffs[8:2] == WRCNT_OFFS[8:2]);
      hit_id_o    = in_range && (loffs[8:2] == ID_OFFS[8:2]);
      hit_cfg_o   = in_range && (loffs[8] == CFG_OFFS[8])
                    && ({1'b0, idx_o} < NCFG);
      hit_stat_o  = in_range && (loffs[8] == STAT_OFFS[8])
                    && !hit_wrcnt_o && !hit_id_o
                    && ({1'b0, idx_o} < NSTAT);
   end

endmodule

// File: rtl/wb_cfg_slave.sv
// Wishbone classic slave holding queue-core config and status words.
// Build option: WB_CFG_PIPE_EN inserts a DECODE state before commit.
module wb_cfg_slave
   import wb_cfg_pkg::*;
#(
   parameter int                    DATA_WIDTH    = 32,
   parameter int                    ADDR_WIDTH    = 32,
   parameter int                    NUM_CFG_REGS  = 8,
   parameter int                    NUM_STAT_REGS = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
   parameter logic [NUM_CFG_REGS*DATA_WIDTH-1:0] CFG_RESET = '0
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                wb_cyc_i,
   input  logic                                wb_stb_i,
   input  logic                                wb_we_i,
   input  logic [ADDR_WIDTH-1:0]               wb_addr_i,
   input  logic [DATA_WIDTH-1:0]               wb_data_i,
   output logic [DATA_WIDTH-1:0]               wb_data_o,
   output logic                                wb_ack_o,
   output logic [NUM_CFG_REGS*DATA_WIDTH-1:0]  cfg_o,
   output logic [NUM_CFG_REGS-1:0]             cfg_wr_pulse_o,
   input  logic [NUM_STAT_REGS*DATA_WIDTH-1:0] stat_i
);

   state_e                  state_q, state_d;
   dec_t                    dec_live, cmt_dec;
   logic                    req;
   logic                    cmt_vld;
   logic                    cmt_we;
   logic [DATA_WIDTH-1:0]   cmt_wdata;
   logic [DATA_WIDTH-1:0]   cfg_q [NUM_CFG_REGS];
   logic [DATA_WIDTH-1:0]   cfg_d [NUM_CFG_REGS];
   logic [NUM_CFG_REGS-1:0] pulse_q, pulse_d;
   logic [DATA_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

   wb_cfg_decode #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .NUM_CFG_REGS  (NUM_CFG_REGS),
      .NUM_STAT_REGS (NUM_STAT_REGS),
      .BASE_ADDR     (BASE_ADDR)
   ) u_dec (
      .addr_i      (wb_addr_i),
      .hit_cfg_o   (dec_live.hit_cfg),
      .hit_stat_o  (dec_live.hit_stat),
      .hit_wrcnt_o (dec_live.hit_wrcnt),
      .hit_id_o    (dec_live.hit_id),
      .idx_o       (dec_live.idx)
   );

   // Strobe is only sampled from IDLE, so ACK never re-triggers.
   assign req = wb_cyc_i & wb_stb_i & (state_q == IDLE);

`ifdef WB_CFG_PIPE_EN
   localparam state_e REQ_NEXT = DECODE;

   dec_t                  dec_q, dec_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   always_comb begin
      dec_d   = dec_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      if (req) begin
         dec_d   = dec_live;
         we_d    = wb_we_i;
         wdata_d = wb_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dec_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         dec_q   <= dec_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
      end
   end

   assign cmt_vld   = (state_q == DECODE);
   assign cmt_dec   = dec_q;
   assign cmt_we    = we_q;
   assign cmt_wdata = wdata_q;
`else
   localparam state_e REQ_NEXT = ACK;

   assign cmt_vld   = req;
   assign cmt_dec   = dec_live;
   assign cmt_we    = wb_we_i;
   assign cmt_wdata = wb_data_i;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (req) state_d = REQ_NEXT;
         DECODE:  state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cfg_d    = cfg_q;
      pulse_d  = '0;
      wr_cnt_d = wr_cnt_q;
      rdata_d  = rdata_q;
      if (cmt_vld) begin
         if (cmt_we) begin
            // Ignored writes still count as accepted.
            wr_cnt_d = wr_cnt_q + DATA_WIDTH'(1);
            for (int i = 0; i < NUM_CFG_REGS; i++) begin
               if (cmt_dec.hit_cfg && cmt_dec.idx == 6'(i)) begin
                  cfg_d[i]   = cmt_wdata;
                  pulse_d[i] = 1'b1;
               end
            end
         end else begin
            rdata_d = UNMAPPED_VALUE;
            for (int i = 0; i < NUM_CFG_REGS; i++) begin
               if (cmt_dec.hit_cfg && cmt_dec.idx == 6'(i))
                  rdata_d = cfg_q[i];
            end
            for (int j = 0; j < NUM_STAT_REGS; j++) begin
               if (cmt_dec.hit_stat && cmt_dec.idx == 6'(j))
                  rdata_d = stat_i[j*DATA_WIDTH +: DATA_WIDTH];
            end
            if (cmt_dec.hit_wrcnt) rdata_d = wr_cnt_q;
            if (cmt_dec.hit_id)    rdata_d = ID_VALUE;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         pulse_q  <= '0;
         wr_cnt_q <= '0;
         rdata_q  <= '0;
         for (int i = 0; i < NUM_CFG_REGS; i++)
            cfg_q[i] <= CFG_RESET[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
         state_q  <= state_d;
         pulse_q  <= pulse_d;
         wr_cnt_q <= wr_cnt_d;
         rdata_q  <= rdata_d;
         cfg_q    <= cfg_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CFG_REGS; i++)
         cfg_o[i*DATA_WIDTH +: DATA_WIDTH] = cfg_q[i];
   end

   assign wb_ack_o       = (state_q == ACK);
   assign wb_data_o      = rdata_q;
   assign cfg_wr_pulse_o = pulse_q;

endmodule

// File: tb/tb_wb_cfg_slave.sv
// Directed bench for wb_cfg_slave with a read-data scoreboard.
// Latency expectation follows WB_CFG_PIPE_EN when it is defined.
module tb_wb_cfg_slave;

   localparam int NC = 8;
   localparam int NS = 4;
`ifdef WB_CFG_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam logic [NC*32-1:0] CFG_RST =
      {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hAA, 32'h0, 32'h0};
   localparam logic [31:0] IDV = 32'h5146_0100;
   localparam logic [31:0] UNM = 32'hDEAD_BEEF;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            cyc = 1'b0;
   logic            stb = 1'b0;
   logic            we  = 1'b0;
   logic [31:0]     addr = '0;
   logic [31:0]     wdata = '0;
   logic [31:0]     rdata;
   logic            ack;
   logic [NC*32-1:0] cfg_o;
   logic [NC-1:0]   pulse;
   logic [NS*32-1:0] stat = '0;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] sb [$];
   logic [31:0] wcnt = '0;
   logic [31:0] last_rd = '0;

   always #5 clk = ~clk;

   wb_cfg_slave #(
      .DATA_WIDTH    (32),
      .ADDR_WIDTH    (32),
      .NUM_CFG_REGS  (NC),
      .NUM_STAT_REGS (NS),
      .BASE_ADDR     (32'h0),
      .CFG_RESET     (CFG_RST)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .wb_cyc_i       (cyc),
      .wb_stb_i       (stb),
      .wb_we_i        (we),
      .wb_addr_i      (addr),
      .wb_data_i      (wdata),
      .wb_data_o      (rdata),
      .wb_ack_o       (ack),
      .cfg_o          (cfg_o),
      .cfg_wr_pulse_o (pulse),
      .stat_i         (stat)
   );

   function automatic logic [31:0] cfg_at(int i);
      return cfg_o[i*32 +: 32];
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Ends on the sample point of the ack cycle.
   task automatic access(string tag, logic w, logic [31:0] a,
                         logic [31:0] d, logic [31:0] rexp,
                         logic [7:0] pexp);
      int k;
      logic [31:0] e;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
      if (w) wcnt++;
      else sb.push_back(rexp);
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!ack && k < 6);
      chk({tag, "_lat"}, 32'(k), 32'(LAT));
      if (!w && sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_rd"}, rdata, e);
         last_rd = e;
      end else begin
         chk({tag, "_hold"}, rdata, last_rd);
      end
      chk({tag, "_pulse"}, 32'(pulse), 32'(pexp));
   endtask

   task automatic after_ack(string tag);
      @(negedge clk);
      chk({tag, "_ackdrop"}, 32'(ack), 32'd0);
      chk({tag, "_pdrop"}, 32'(pulse), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int nack;
      int b2b;
      logic prev;
      logic [31:0] e;

      repeat (3) @(negedge clk);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_data", rdata, 32'd0);
      chk("rst_pulse", 32'(pulse), 32'd0);
      chk("rst_cfg2", cfg_at(2), 32'hAA);
      chk("rst_cfg0", cfg_at(0), 32'h0);
      rst = 1'b0;

      access("rd_cfg2", 1'b0, 32'h008, 32'h0, 32'hAA, 8'h00);
      after_ack("rd_cfg2");
      access("rd_id", 1'b0, 32'h1FC, 32'h0, IDV, 8'h00);
      after_ack("rd_id");

      access("wr_cfg1", 1'b1, 32'h004, 32'h1234_5678, 32'h0, 8'h02);
      chk("wr_cfg1_val", cfg_at(1), 32'h1234_5678);
      after_ack("wr_cfg1");
      access("rb_cfg1", 1'b0, 32'h004, 32'h0, 32'h1234_5678, 8'h00);
      after_ack("rb_cfg1");
      access("rd_wrcnt1", 1'b0, 32'h1F8, 32'h0, wcnt, 8'h00);
      after_ack("rd_wrcnt1");

      stat[3*32 +: 32] = 32'hCAFE_0003;
      access("rd_stat3", 1'b0, 32'h10C, 32'h0, 32'hCAFE_0003, 8'h00);
      stat[3*32 +: 32] = 32'h1111_2222;
      after_ack("rd_stat3");
      chk("stat_hold", rdata, 32'hCAFE_0003);

      access("rd_unpop", 1'b0, 32'h020, 32'h0, UNM, 8'h00);
      after_ack("rd_unpop");
      access("rd_oor", 1'b0, 32'h400, 32'h0, UNM, 8'h00);
      after_ack("rd_oor");
      access("wr_ign", 1'b1, 32'h1F0, 32'hFFFF_FFFF, 32'h0, 8'h00);
      after_ack("wr_ign");
      chk("ign_cfg0", cfg_at(0), 32'h0);
      chk("ign_cfg1", cfg_at(1), 32'h1234_5678);
      access("rd_wrcnt2", 1'b0, 32'h1F8, 32'h0, wcnt, 8'h00);
      after_ack("rd_wrcnt2");

      // Strobe held across four sampling edges.
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h1FC;
      sb.push_back(IDV);
      sb.push_back(IDV);
      nack = 0; b2b = 0; prev = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ack) begin
            nack++;
            if (prev) b2b++;
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("hold_rd", rdata, e);
            end
         end
         prev = ack;
         if (i == 3) begin cyc = 1'b0; stb = 1'b0; end
      end
      chk("hold_nack", 32'(nack), 32'd2);
      chk("hold_b2b", 32'(b2b), 32'd0);
      chk("hold_sb", 32'(sb.size()), 32'd0);
      sb.delete();
      last_rd = IDV;

      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h000;
      wdata = 32'h5555_5555; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      wcnt = '0; last_rd = '0;
      chk("mrst_ack", 32'(ack), 32'd0);
      chk("mrst_pulse", 32'(pulse), 32'd0);
      chk("mrst_cfg0", cfg_at(0), 32'h0);
      chk("mrst_cfg1", cfg_at(1), 32'h0);
      chk("mrst_data", rdata, 32'h0);
      @(negedge clk);
      chk("mrst_ack2", 32'(ack), 32'd0);
      access("mrst_wrcnt", 1'b0, 32'h1F8, 32'h0, 32'h0, 8'h00);
      after_ack("mrst_wrcnt");
      access("mrst_cfg0rd", 1'b0, 32'h000, 32'h0, 32'h0, 8'h00);
      after_ack("mrst_cfg0rd");
      access("mrst_cfg2rd", 1'b0, 32'h008, 32'h0, 32'hAA, 8'h00);
      after_ack("mrst_cfg2rd");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
